ttm4_sequencer: RTL and testbench



---
 rtl/ttm4_pkg.sv | 65 ++++++
 rtl/ttm4_decode.sv | 53 +++++
 rtl/ttm4_sequencer.sv | 145 ++++++++++++++
 tb/tb_ttm4_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ttm4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ttm4_pkg
// Description : Shared definitions for the TTM4 control stage: opcode codes,
//               sequencer state encoding, LD/ST nibble select codes, the
//               accumulator write-back selector and the decoder output record.
// Revision    : 1.0 - initial release
// ============================================================================
package ttm4_pkg;

    // Instruction opcodes (ROM_DATA[7:4]); 0x7-0xF are reserved and act as NOP
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JNC  = 4'h6;

    // Nibble select codes from imm[1:0]. Codes 2/3 address the O-register
    // nibbles for ST and the I-register nibbles for LD.
    localparam logic [1:0] SEL_JRD = 2'd0;
    localparam logic [1:0] SEL_JRU = 2'd1;
    localparam logic [1:0] SEL_XRD = 2'd2;
    localparam logic [1:0] SEL_XRU = 2'd3;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_NEXT  = 2'd2
    } state_t;

    // What the accumulator/carry pair does at the end of EXEC
    typedef enum logic [2:0] {
        WB_NONE = 3'd0,
        WB_IMM  = 3'd1,
        WB_ADD  = 3'd2,
        WB_LOAD = 3'd3,
        WB_CLRC = 3'd4
    } wb_sel_t;

    // Active-high decode result; the top inverts it into the n* strobes
    typedef struct packed {
        logic       pc_ld;
        logic [3:0] st;    // [0]=JRD [1]=JRU [2]=ORD [3]=ORU
        logic [3:0] out;   // [0]=JRD [1]=JRU [2]=IRD [3]=IRU
        logic       jump;
        wb_sel_t    wb;
    } dec_t;

    // One-hot strobe position for a nibble select code
    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        logic [3:0] v;
        case (sel)
            SEL_JRD: v = 4'b0001;
            SEL_JRU: v = 4'b0010;
            SEL_XRD: v = 4'b0100;
            SEL_XRU: v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ttm4_decode.sv
`default_nettype none
// ============================================================================
// Module      : ttm4_decode
// Description : Combinational instruction decoder. Maps opcode, nibble select
//               and current carry onto the strobe set, jump-taken flag and
//               accumulator write-back selector.
// Ports       : i_opcode  - instruction opcode [7:4]
//               i_sel     - immediate bits [1:0] (LD/ST nibble select)
//               i_carry   - current C flag (JNC condition)
//               o_dec     - decoded strobes (active high), jump, write-back
// Revision    : 1.0 - initial release
// ============================================================================
module ttm4_decode
    import ttm4_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic [1:0] i_sel,
    input  logic       i_carry,
    output dec_t       o_dec
);

    always_comb begin
        o_dec.pc_ld = 1'b0;
        o_dec.st    = 4'b0000;
        o_dec.out   = 4'b0000;
        o_dec.jump  = 1'b0;
        o_dec.wb    = WB_NONE;
        case (i_opcode)
            OP_NOP:  o_dec.wb = WB_NONE;
            OP_LDI:  o_dec.wb = WB_IMM;
            OP_ADDI: o_dec.wb = WB_ADD;
            OP_LD: begin
                o_dec.out = sel_onehot(i_sel);
                o_dec.wb  = WB_LOAD;
            end
            OP_ST:   o_dec.st = sel_onehot(i_sel);
            OP_JMP: begin
                o_dec.pc_ld = 1'b1;
                o_dec.jump  = 1'b1;
                o_dec.wb    = WB_CLRC;
            end
            OP_JNC: begin
                // Carry is cleared whether or not the branch is taken
                o_dec.pc_ld = ~i_carry;
                o_dec.jump  = ~i_carry;
                o_dec.wb    = WB_CLRC;
            end
            default: o_dec.wb = WB_NONE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ttm4_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ttm4_sequencer
// Description : TTM4 control stage. Fetches the instruction at the current PC,
//               runs it for STROBE_CYCLES clocks with registered active-low
//               strobes, owns accumulator A and carry C, then pulses nPC_INC
//               (unless a jump was taken) before the next fetch.
// Ports       : CLK, RST (async, active high), RUN, ROM_DATA[7:0],
//               LOADBUS[3:0] in; STOREBUS[3:0] (=A), nPC_INC, nPC_LD,
//               n*_ST / n*_OUT strobes, CARRY, STATE[1:0] out.
// Revision    : 1.0 - initial release
// ============================================================================
module ttm4_sequencer
    import ttm4_pkg::*;
#(
    parameter int STROBE_CYCLES = 1,
    parameter int NIB_W         = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic [7:0]       ROM_DATA,
    input  logic [NIB_W-1:0] LOADBUS,
    output logic [NIB_W-1:0] STOREBUS,
    output logic             nPC_INC,
    output logic             nPC_LD,
    output logic             nJRD_ST,
    output logic             nJRU_ST,
    output logic             nORD_ST,
    output logic             nORU_ST,
    output logic             nJRD_OUT,
    output logic             nJRU_OUT,
    output logic             nIRD_OUT,
    output logic             nIRU_OUT,
    output logic             CARRY,
    output logic [1:0]       STATE
);

    localparam logic [3:0] c_CNT_INIT = 4'(STROBE_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_irq, w_irq_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [NIB_W-1:0] r_a, w_a_nxt;
    logic             r_c, w_c_nxt;
    // {pc_ld, st[3:0], out[3:0]}, active low
    logic [8:0]       r_strb_n, w_strb_n_nxt;
    logic             r_inc_n, w_inc_n_nxt;

    logic [3:0]       w_dec_op;
    logic [1:0]       w_dec_sel;
    dec_t             w_dec;
    logic [8:0]       w_dec_strb_n;
    logic [NIB_W:0]   w_sum;

    // In FETCH the instruction being latched is decoded straight from ROM so
    // the registered strobes are already low in the first EXEC cycle.
    assign w_dec_op  = (r_state == ST_FETCH) ? ROM_DATA[7:4] : r_irq[7:4];
    assign w_dec_sel = (r_state == ST_FETCH) ? ROM_DATA[1:0] : r_irq[1:0];

    ttm4_decode u_decode (
        .i_opcode (w_dec_op),
        .i_sel    (w_dec_sel),
        .i_carry  (r_c),
        .o_dec    (w_dec)
    );

    assign w_dec_strb_n = ~{w_dec.pc_ld, w_dec.st, w_dec.out};
    assign w_sum        = {1'b0, r_a} + {1'b0, r_irq[3:0]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_FETCH;
            r_irq    <= 8'h00;
            r_cnt    <= 4'd0;
            r_a      <= '0;
            r_c      <= 1'b0;
            r_strb_n <= 9'h1FF;
            r_inc_n  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_irq    <= w_irq_nxt;
            r_cnt    <= w_cnt_nxt;
            r_a      <= w_a_nxt;
            r_c      <= w_c_nxt;
            r_strb_n <= w_strb_n_nxt;
            r_inc_n  <= w_inc_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_irq_nxt    = r_irq;
        w_cnt_nxt    = r_cnt;
        w_a_nxt      = r_a;
        w_c_nxt      = r_c;
        w_strb_n_nxt = 9'h1FF;
        w_inc_n_nxt  = 1'b1;
        case (r_state)
            ST_FETCH: begin
                if (RUN) begin
                    w_irq_nxt    = ROM_DATA;
                    w_cnt_nxt    = c_CNT_INIT;
                    w_state_nxt  = ST_EXEC;
                    w_strb_n_nxt = w_dec_strb_n;
                end
            end
            ST_EXEC: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt    = r_cnt - 4'd1;
                    w_strb_n_nxt = w_dec_strb_n;
                end else begin
                    // Last EXEC cycle: commit A/C and schedule the PC step
                    w_state_nxt = ST_NEXT;
                    w_inc_n_nxt = w_dec.jump;
                    case (w_dec.wb)
                        WB_IMM:  w_a_nxt = r_irq[3:0];
                        WB_ADD:  {w_c_nxt, w_a_nxt} = w_sum;
                        WB_LOAD: w_a_nxt = LOADBUS;
                        WB_CLRC: w_c_nxt = 1'b0;
                        default: w_a_nxt = r_a;
                    endcase
                end
            end
            ST_NEXT: w_state_nxt = ST_FETCH;
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    assign STOREBUS = r_a;
    assign CARRY    = r_c;
    assign STATE    = r_state;
    assign nPC_INC  = r_inc_n;
    assign nPC_LD   = r_strb_n[8];
    assign nORU_ST  = r_strb_n[7];
    assign nORD_ST  = r_strb_n[6];
    assign nJRU_ST  = r_strb_n[5];
    assign nJRD_ST  = r_strb_n[4];
    assign nIRU_OUT = r_strb_n[3];
    assign nIRD_OUT = r_strb_n[2];
    assign nJRU_OUT = r_strb_n[1];
    assign nJRD_OUT = r_strb_n[0];

endmodule
`default_nettype wire

// File: tb/tb_ttm4_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ttm4_sequencer
// Description : Self-checking bench for ttm4_sequencer. Two instances share
//               clock and reset: u_dut1 (STROBE_CYCLES=1), u_dut3 (=3).
//               Strobe vector order: {nPC_LD, nJRD_ST, nJRU_ST, nORD_ST,
//               nORU_ST, nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ttm4_sequencer;

    typedef struct {
        logic [8:0] strb;
        logic       inc;
        logic [3:0] a;
        logic       c;
    } exp_t;

    typedef struct {
        logic [7:0] instr;
        logic [3:0] lb;
        exp_t       e;
    } vec_t;

    logic       tb_CLK = 1'b0;
    logic       rst;
    logic       run_in [2];
    logic [7:0] rom    [2];
    logic [3:0] lbv    [2];
    logic [3:0] m_a    [2];
    logic       m_c    [2];
    int         errors = 0;
    int         checks = 0;

    logic [3:0] lb_0, sb_0, lb_3, sb_3;
    logic inc_0, ld_0, jrd_st_0, jru_st_0, ord_st_0, oru_st_0;
    logic jrd_o_0, jru_o_0, ird_o_0, iru_o_0, cy_0;
    logic inc_3, ld_3, jrd_st_3, jru_st_3, ord_st_3, oru_st_3;
    logic jrd_o_3, jru_o_3, ird_o_3, iru_o_3, cy_3;
    logic [1:0] st_0, st_3;

    always #5 tb_CLK = ~tb_CLK;

    // Register block model: drives the requested nibble only while an OUT strobe is low
    assign lb_0 = (&{jrd_o_0, jru_o_0, ird_o_0, iru_o_0}) ? 4'h0 : lbv[0];
    assign lb_3 = (&{jrd_o_3, jru_o_3, ird_o_3, iru_o_3}) ? 4'h0 : lbv[1];

    ttm4_sequencer #(.STROBE_CYCLES(1), .NIB_W(4)) u_dut1 (
        .CLK(tb_CLK), .RST(rst), .RUN(run_in[0]), .ROM_DATA(rom[0]), .LOADBUS(lb_0),
        .STOREBUS(sb_0), .nPC_INC(inc_0), .nPC_LD(ld_0),
        .nJRD_ST(jrd_st_0), .nJRU_ST(jru_st_0), .nORD_ST(ord_st_0), .nORU_ST(oru_st_0),
        .nJRD_OUT(jrd_o_0), .nJRU_OUT(jru_o_0), .nIRD_OUT(ird_o_0), .nIRU_OUT(iru_o_0),
        .CARRY(cy_0), .STATE(st_0)
    );

    ttm4_sequencer #(.STROBE_CYCLES(3), .NIB_W(4)) u_dut3 (
        .CLK(tb_CLK), .RST(rst), .RUN(run_in[1]), .ROM_DATA(rom[1]), .LOADBUS(lb_3),
        .STOREBUS(sb_3), .nPC_INC(inc_3), .nPC_LD(ld_3),
        .nJRD_ST(jrd_st_3), .nJRU_ST(jru_st_3), .nORD_ST(ord_st_3), .nORU_ST(oru_st_3),
        .nJRD_OUT(jrd_o_3), .nJRU_OUT(jru_o_3), .nIRD_OUT(ird_o_3), .nIRU_OUT(iru_o_3),
        .CARRY(cy_3), .STATE(st_3)
    );

    function automatic logic [8:0] strb(input int d);
        if (d == 0)
            return {ld_0, jrd_st_0, jru_st_0, ord_st_0, oru_st_0, jrd_o_0, jru_o_0, ird_o_0, iru_o_0};
        return {ld_3, jrd_st_3, jru_st_3, ord_st_3, oru_st_3, jrd_o_3, jru_o_3, ird_o_3, iru_o_3};
    endfunction
    function automatic logic [1:0] st(input int d);  return (d == 0) ? st_0 : st_3;   endfunction
    function automatic logic       inc(input int d); return (d == 0) ? inc_0 : inc_3; endfunction
    function automatic logic [3:0] sb(input int d);  return (d == 0) ? sb_0 : sb_3;   endfunction
    function automatic logic       cy(input int d);  return (d == 0) ? cy_0 : cy_3;   endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level reference: effect of one instruction on A/C and which strobes fire
    function automatic exp_t model(input logic [7:0] ins, input logic [3:0] a,
                                   input logic c, input logic [3:0] lb);
        exp_t e;
        int   sel;
        int   sum;
        sel    = int'(ins[1:0]);
        e.strb = 9'h1FF;
        e.inc  = 1'b0;
        e.a    = a;
        e.c    = c;
        case (ins[7:4])
            4'h1: e.a = ins[3:0];
            4'h2: begin
                sum = int'(a) + int'(ins[3:0]);
                e.a = 4'(sum % 16);
                e.c = (sum > 15);
            end
            4'h3: begin e.strb[3 - sel] = 1'b0; e.a = lb; end
            4'h4: e.strb[7 - sel] = 1'b0;
            4'h5: begin e.strb[8] = 1'b0; e.inc = 1'b1; e.c = 1'b0; end
            4'h6: begin
                if (!c) begin e.strb[8] = 1'b0; e.inc = 1'b1; end
                e.c = 1'b0;
            end
            default: e.strb = 9'h1FF;
        endcase
        return e;
    endfunction

    // Run one instruction starting from a FETCH-state negedge and check every cycle
    task automatic run_check(input int d, input logic [7:0] instr, input logic [3:0] lb, input exp_t e);
        int sc;
        sc = (d == 0) ? 1 : 3;
        rom[d] = instr; lbv[d] = lb; run_in[d] = 1'b1;
        chk("fetch_state", 32'(st(d)), 32'd0);
        chk("fetch_strobes", 32'(strb(d)), 32'h1FF);
        @(negedge tb_CLK);
        // RUN drop and ROM change mid-instruction must not disturb it
        run_in[d] = 1'b0; rom[d] = 8'($urandom);
        for (int i = 0; i < sc; i++) begin
            chk("exec_state", 32'(st(d)), 32'd1);
            chk("exec_strobes", 32'(strb(d)), 32'(e.strb));
            chk("exec_pc_inc", 32'(inc(d)), 32'd1);
            @(negedge tb_CLK);
        end
        chk("next_state", 32'(st(d)), 32'd2);
        chk("next_pc_inc", 32'(inc(d)), 32'(e.inc));
        chk("next_strobes", 32'(strb(d)), 32'h1FF);
        @(negedge tb_CLK);
        chk("storebus", 32'(sb(d)), 32'(e.a));
        chk("carry", 32'(cy(d)), 32'(e.c));
        chk("pc_inc_idle", 32'(inc(d)), 32'd1);
        m_a[d] = e.a;
        m_c[d] = e.c;
    endtask

    task automatic run_model(input int d, input logic [7:0] instr, input logic [3:0] lb);
        run_check(d, instr, lb, model(instr, m_a[d], m_c[d], lb));
    endtask

    function automatic vec_t row(input logic [7:0] i, input logic [3:0] lb, input logic [8:0] s,
                                 input logic n, input logic [3:0] a, input logic c);
        vec_t v;
        v.instr = i; v.lb = lb;
        v.e.strb = s; v.e.inc = n; v.e.a = a; v.e.c = c;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            run_in[d] = 1'b0; rom[d] = 8'h00; lbv[d] = 4'h0; m_a[d] = 4'h0; m_c[d] = 1'b0;
        end

        // Hand-computed directed sequence, identical expectations for both instances
        tbl.push_back(row(8'h15, 4'h0, 9'h1FF, 1'b0, 4'h5, 1'b0)); // LDI 5
        tbl.push_back(row(8'h40, 4'h0, 9'h17F, 1'b0, 4'h5, 1'b0)); // ST JRD
        tbl.push_back(row(8'h1F, 4'h0, 9'h1FF, 1'b0, 4'hF, 1'b0)); // LDI F
        tbl.push_back(row(8'h21, 4'h0, 9'h1FF, 1'b0, 4'h0, 1'b1)); // ADDI wrap
        tbl.push_back(row(8'h60, 4'h0, 9'h1FF, 1'b0, 4'h0, 1'b0)); // JNC not taken
        tbl.push_back(row(8'h50, 4'h0, 9'h0FF, 1'b1, 4'h0, 1'b0)); // JMP
        tbl.push_back(row(8'h32, 4'hA, 9'h1FD, 1'b0, 4'hA, 1'b0)); // LD IRD
        tbl.push_back(row(8'h27, 4'h0, 9'h1FF, 1'b0, 4'h1, 1'b1)); // ADDI 7 carry
        tbl.push_back(row(8'h60, 4'h0, 9'h1FF, 1'b0, 4'h1, 1'b0)); // JNC, C=1
        tbl.push_back(row(8'h60, 4'h0, 9'h0FF, 1'b1, 4'h1, 1'b0)); // JNC, C=0 taken
        tbl.push_back(row(8'h4F, 4'h0, 9'h1EF, 1'b0, 4'h1, 1'b0)); // ST ORU, imm[3:2] ignored
        tbl.push_back(row(8'h45, 4'h0, 9'h1BF, 1'b0, 4'h1, 1'b0)); // ST JRU
        tbl.push_back(row(8'h42, 4'h0, 9'h1DF, 1'b0, 4'h1, 1'b0)); // ST ORD
        tbl.push_back(row(8'h3D, 4'h6, 9'h1FB, 1'b0, 4'h6, 1'b0)); // LD JRU
        tbl.push_back(row(8'h3C, 4'h3, 9'h1F7, 1'b0, 4'h3, 1'b0)); // LD JRD
        tbl.push_back(row(8'h3B, 4'h9, 9'h1FE, 1'b0, 4'h9, 1'b0)); // LD IRU
        tbl.push_back(row(8'h9A, 4'h0, 9'h1FF, 1'b0, 4'h9, 1'b0)); // reserved
        tbl.push_back(row(8'h00, 4'h0, 9'h1FF, 1'b0, 4'h9, 1'b0)); // NOP

        repeat (2) @(negedge tb_CLK);
        chk("reset_strobes", 32'(strb(0)), 32'h1FF);
        rst = 1'b0;
        @(negedge tb_CLK);
        for (int d = 0; d < 2; d++) begin
            chk("reset_state", 32'(st(d)), 32'd0);
            chk("reset_strobes", 32'(strb(d)), 32'h1FF);
            chk("reset_pc_inc", 32'(inc(d)), 32'd1);
            chk("reset_storebus", 32'(sb(d)), 32'd0);
            chk("reset_carry", 32'(cy(d)), 32'd0);
        end

        // NOP stream with RUN held: STATE 0,1,2 and one nPC_INC pulse per 3 clocks
        rom[0] = 8'h00;
        for (int k = 0; k < 9; k++) begin
            run_in[0] = 1'b1;
            chk("nop_state", 32'(st(0)), 32'(k % 3));
            chk("nop_pc_inc", 32'(inc(0)), (k % 3 == 2) ? 32'd0 : 32'd1);
            chk("nop_strobes", 32'(strb(0)), 32'h1FF);
            @(negedge tb_CLK);
        end
        run_in[0] = 1'b0;
        @(negedge tb_CLK);
        chk("hold_in_fetch", 32'(st(0)), 32'd0);

        for (int d = 0; d < 2; d++)
            foreach (tbl[i]) run_check(d, tbl[i].instr, tbl[i].lb, tbl[i].e);

        // Randomised instruction streams against the reference model
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 40; n++) begin
                int op;
                op = int'($urandom_range(0, 8));
                run_model(d, {4'(op), 4'($urandom)}, 4'($urandom));
            end
        end

        // Asynchronous reset in the middle of a 3-cycle ST ORU
        run_model(1, 8'h1C, 4'h0);
        rom[1] = 8'h43; run_in[1] = 1'b1;
        @(negedge tb_CLK);
        run_in[1] = 1'b0;
        chk("rst_pre_oru", 32'(strb(1)), 32'h1EF);
        @(negedge tb_CLK);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_strobes", 32'(strb(1)), 32'h1FF);
        chk("rst_async_storebus", 32'(sb(1)), 32'd0);
        chk("rst_async_state", 32'(st(1)), 32'd0);
        chk("rst_async_carry", 32'(cy(1)), 32'd0);
        @(negedge tb_CLK);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin m_a[d] = 4'h0; m_c[d] = 1'b0; end
        @(negedge tb_CLK);
        run_model(1, 8'h15, 4'h0);
        run_model(1, 8'h43, 4'h0);
        run_model(1, 8'h2C, 4'h0);
        run_model(0, 8'h21, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
